regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A (ALU writeback) and B (memory-load writeback).
- Arbitrates round-robin on conflict, registers the winning write, and drives load/address/data to the register file one cycle later.
- Writes to register 0 are accepted and then discarded, so the write port never toggles load for address 0.
- Keeps a saturating conflict counter for performance debug.

---
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 tb/tb_regfile_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B)
// writeback, one registered write per cycle, register-0 writes swallowed,
// saturating conflict counter for performance debug.
module regfile_write_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR  = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             a_valid,
  input  logic [ADDR-1:0]  a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [ADDR-1:0]  b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             wr_load,
  output logic [ADDR-1:0]  wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             prio_b,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } arb_state_t;

  arb_state_t state;

  logic             arb_en;
  logic             conflict;
  logic             grant_a;
  logic             grant_b;
  logic [ADDR-1:0]  sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Grant decision: preferred side wins a conflict; reset and stall block all grants
  always_comb begin
    arb_en   = !rst && !stall;
    conflict = a_valid && b_valid;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (arb_en) begin
      if (conflict) begin
        grant_a = (state == PREF_A);
        grant_b = (state == PREF_B);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign prio_b  = (state == PREF_B);

  // Arbitration state, output stage and conflict counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PREF_A;
      wr_load      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_a || grant_b) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        // Register 0 is hardwired; the slot is consumed but nothing is written
        wr_load <= (sel_addr != '0);
        if (conflict) begin
          state <= grant_a ? PREF_B : PREF_A;
        end
      end else begin
        wr_load <= 1'b0;
      end
      if (arb_en && conflict && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: table-driven vectors with a
// scoreboard of expected register-file writes, plus hand-written sequences.
module tb_regfile_write_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ADDR  = 5;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             a_valid;
  logic [ADDR-1:0]  a_addr;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [ADDR-1:0]  b_addr;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             wr_load;
  logic [ADDR-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             prio_b;
  logic [CNT_W-1:0] conflict_cnt;

  regfile_write_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .wr_load      (wr_load),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .prio_b       (prio_b),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             stall;
    logic             av;
    logic [ADDR-1:0]  aa;
    logic [WIDTH-1:0] ad;
    logic             bv;
    logic [ADDR-1:0]  ba;
    logic [WIDTH-1:0] bd;
    logic             ear;
    logic             ebr;
    logic             eprio;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  typedef struct {
    logic             load;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  vec_t             vecs[$];
  wr_t              exp_q[$];
  logic [ADDR-1:0]  last_addr;
  logic [WIDTH-1:0] last_data;
  int               n_vec;
  int               n_cmp;
  int               n_fail;

  function automatic vec_t mk(input logic r, input logic s,
                              input logic av, input logic [ADDR-1:0] aa, input logic [WIDTH-1:0] ad,
                              input logic bv, input logic [ADDR-1:0] ba, input logic [WIDTH-1:0] bd,
                              input logic ear, input logic ebr, input logic eprio,
                              input logic [CNT_W-1:0] ecnt);
    vec_t v;
    v.rst = r;   v.stall = s;
    v.av  = av;  v.aa = aa; v.ad = ad;
    v.bv  = bv;  v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.eprio = eprio; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int idx);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
    end
  endtask

  // Drive one vector, check readies mid-cycle, check registered outputs after the edge
  task automatic apply(input vec_t v);
    wr_t e;
    wr_t got;
    int  idx;
    idx     = n_vec;
    n_vec++;
    rst     = v.rst;
    stall   = v.stall;
    a_valid = v.av;
    a_addr  = v.aa;
    a_data  = v.ad;
    b_valid = v.bv;
    b_addr  = v.ba;
    b_data  = v.bd;
    @(negedge clk);
    chk("a_ready", 64'(a_ready), 64'(v.ear), idx);
    chk("b_ready", 64'(b_ready), 64'(v.ebr), idx);
    if (v.rst) begin
      e.load = 1'b0; e.addr = '0; e.data = '0;
    end else if (v.ear) begin
      e.load = (v.aa != '0); e.addr = v.aa; e.data = v.ad;
    end else if (v.ebr) begin
      e.load = (v.ba != '0); e.addr = v.ba; e.data = v.bd;
    end else begin
      e.load = 1'b0; e.addr = last_addr; e.data = last_data;
    end
    last_addr = e.addr;
    last_data = e.data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL vec%0d scoreboard: got empty queue, expected one entry", idx);
    end else begin
      got = exp_q.pop_front();
      chk("wr_load", 64'(wr_load), 64'(got.load), idx);
      chk("wr_addr", 64'(wr_addr), 64'(got.addr), idx);
      chk("wr_data", 64'(wr_data), 64'(got.data), idx);
    end
    chk("prio_b", 64'(prio_b), 64'(v.eprio), idx);
    chk("conflict_cnt", 64'(conflict_cnt), 64'(v.ecnt), idx);
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0;
    last_addr = '0; last_data = '0;
    rst = 1'b1; stall = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    @(posedge clk);
    #1;

    // reset with a pending A request: no grant, outputs cleared
    vecs.push_back(mk(1, 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 0, 0, 2'd0));
    // single requester, one-cycle latency, then idle
    vecs.push_back(mk(0, 0, 1, 5'd5, 32'h0000BABE, 0, 5'd0, 32'h0, 1, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 0, 0, 0, 2'd0));
    // conflict: A wins, then B alone
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 0, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 1, 2'd1));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 1, 2'd1));
    // register zero discarded, then a real write
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hDEADBEEF, 0, 1, 1, 2'd1));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h1111BABE, 0, 1, 1, 2'd1));
    // stall with both valid for 3 cycles, then release: preferred B wins
    vecs.push_back(mk(0, 1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 0, 2'd2));
    // a write in flight across reset, grant suppressed during reset
    vecs.push_back(mk(0, 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 0, 0, 2'd0));
    // saturation: both held valid for 6 cycles, grants alternate
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 1, 0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 1, 0, 2'd2));
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 1, 0, 1, 2'd3));
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 1, 0, 2'd3));
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 1, 0, 1, 2'd3));
    vecs.push_back(mk(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 1, 0, 2'd3));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 2'd3));

    foreach (vecs[i]) apply(vecs[i]);

    // same-address conflict: A lands first, B overwrites on the next cycle
    apply(mk(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 0, 0, 2'd0));
    apply(mk(0, 0, 1, 5'd10, 32'hAAAA, 1, 5'd10, 32'hBBBB, 1, 0, 1, 2'd1));
    apply(mk(0, 0, 0, 5'd10, 32'hAAAA, 1, 5'd10, 32'hBBBB, 0, 1, 1, 2'd1));

    // conflict where the winner targets register 0: slot and priority still consumed
    apply(mk(0, 0, 1, 5'd12, 32'hC0C0, 1, 5'd0, 32'hD0D0, 0, 1, 0, 2'd2));
    apply(mk(0, 0, 1, 5'd12, 32'hC0C0, 0, 5'd0, 32'h0,    1, 0, 0, 2'd2));
    apply(mk(0, 0, 0, 5'd0,  32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 2'd2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
